// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences instruction phases and
// drives datapath selects, the shared-memory handshake and ALUOp.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    input  logic       clear_err_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       err_o,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_ERROR    = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [CW-1:0] r_wait_cnt;
    logic          w_mem_state;
    logic          w_timeout;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // The limit is hit on the waiting cycle that would bring the count to MEM_TIMEOUT.
    assign w_timeout   = w_mem_state && !mem_ready_i && (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready_i)    w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:        w_next = S_EXEC_R;
                    OP_ADDI, OP_SLTI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:    w_next = S_MEM_ADDR;
                    OP_BEQ:          w_next = S_BRANCH;
                    OP_J:            w_next = S_JUMP;
                    default:         w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: w_next = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready_i)    w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_MEM_WR: begin
                if (mem_ready_i)    w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_EXEC_R: w_next = S_R_WB;
            S_EXEC_I: w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_ERROR:  if (clear_err_i) w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || mem_ready_i)
                r_wait_cnt <= '0;
            else if (w_mem_state)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Moore decode, forced to zero while reset is held.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        err_o        = 1'b0;
        if (rst_i) begin
            case (r_state)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'b01;
                    alu_op_o    = 3'b011;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = 2'b11;
                    alu_op_o    = 3'b011;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = 3'b011;
                end
                S_MEM_RD: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                    mem_we_o  = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b010;
                end
                S_R_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = (opcode_i == OP_SLTI) ? 3'b111 : 3'b011;
                end
                S_I_WB:   reg_write_o = 1'b1;
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b001;
                    pc_src_o    = 2'b01;
                    pc_write_o  = zero_i;
                end
                S_JUMP: begin
                    pc_src_o   = 2'b10;
                    pc_write_o = 1'b1;
                end
                S_ERROR: err_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: builds the expected state trace of each
// instruction from its opcode and memory wait lengths, and checks every cycle.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] opcode_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       clear_err_i;
    logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0] pc_src_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic       reg_write_o, reg_dst_o, mem_to_reg_o, err_o;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5;
    localparam int EXEC_R = 6, R_WB = 7, EXEC_I = 8, I_WB = 9, BRANCH = 10, JUMP = 11, ERROR = 15;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .clear_err_i(clear_err_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .iord_o(iord_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .err_o(err_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [16:0] pack_outs();
        return {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o,
                alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o, mem_to_reg_o, err_o};
    endfunction

    // Output table per state, straight from the control description.
    function automatic logic [16:0] exp_out(input int st, input logic [5:0] op,
                                            input logic z, input logic rdy);
        logic req = 0, we = 0, iord = 0, irw = 0, pcw = 0, sa = 0;
        logic rw = 0, rd = 0, m2r = 0, err = 0;
        logic [1:0] pcs = 0, sb = 0;
        logic [2:0] aop = 0;
        case (st)
            FETCH:    begin req = 1; sb = 2'b01; aop = 3'b011; irw = rdy; pcw = rdy; end
            DECODE:   begin sb = 2'b11; aop = 3'b011; end
            MEM_ADDR: begin sa = 1; sb = 2'b10; aop = 3'b011; end
            MEM_RD:   begin req = 1; iord = 1; end
            MEM_WB:   begin rw = 1; m2r = 1; end
            MEM_WR:   begin req = 1; iord = 1; we = 1; end
            EXEC_R:   begin sa = 1; aop = 3'b010; end
            R_WB:     begin rw = 1; rd = 1; end
            EXEC_I:   begin sa = 1; sb = 2'b10; aop = (op == 6'd10) ? 3'b111 : 3'b011; end
            I_WB:     rw = 1;
            BRANCH:   begin sa = 1; aop = 3'b001; pcs = 2'b01; pcw = z; end
            JUMP:     begin pcs = 2'b10; pcw = 1; end
            ERROR:    err = 1;
            default:  ;
        endcase
        return {req, we, iord, irw, pcw, pcs, sa, sb, aop, rw, rd, m2r, err};
    endfunction

    // Entered at posedge+1; applies inputs, checks mid-cycle, returns at next posedge+1.
    task automatic do_cycle(input int st, input logic [5:0] op, input logic z, input logic rdy);
        opcode_i    = op;
        zero_i      = z;
        mem_ready_i = rdy;
        @(negedge clk_i);
        check("state", 32'(state_o), 32'(st));
        check($sformatf("outs_s%0d", st), 32'(pack_outs()), 32'(exp_out(st, op, z, rdy)));
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trace: phase list derived from the opcode, memory phases stretched by waits.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        int tail[$];
        for (int i = 0; i < fw; i++) do_cycle(FETCH, op, z, 1'b0);
        do_cycle(FETCH, op, z, 1'b1);
        do_cycle(DECODE, op, z, rnd_bit());
        case (op)
            6'd0:         tail = '{EXEC_R, R_WB};
            6'd8, 6'd10:  tail = '{EXEC_I, I_WB};
            6'd4:         tail = '{BRANCH};
            6'd2:         tail = '{JUMP};
            6'd35, 6'd43: tail = '{MEM_ADDR};
            default:      tail = '{};
        endcase
        foreach (tail[i]) do_cycle(tail[i], op, z, rnd_bit());
        if (op == 6'd35 || op == 6'd43) begin
            for (int i = 0; i < mw; i++) do_cycle(op == 6'd35 ? MEM_RD : MEM_WR, op, z, 1'b0);
            do_cycle(op == 6'd35 ? MEM_RD : MEM_WR, op, z, 1'b1);
            if (op == 6'd35) do_cycle(MEM_WB, op, z, rnd_bit());
        end
    endtask

    logic [5:0] ops [8] = '{6'd0, 6'd8, 6'd10, 6'd35, 6'd43, 6'd4, 6'd2, 6'd63};

    initial begin
        rst_i = 0; opcode_i = 0; zero_i = 0; mem_ready_i = 0; clear_err_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_state", 32'(state_o), 32'(FETCH));
        check("rst_outs", 32'(pack_outs()), 32'd0);
        rst_i = 1;

        run_instr(6'd0, 0, 0, 0);
        run_instr(6'd35, 0, 0, 3);
        run_instr(6'd4, 1, 0, 0);
        run_instr(6'd4, 0, 1, 0);
        run_instr(6'd43, 0, 0, 2);
        run_instr(6'd2, 0, 0, 0);
        run_instr(6'd8, 0, 0, 0);
        run_instr(6'd10, 0, 2, 0);
        run_instr(6'd63, 0, 0, 0);
        run_instr(6'd0, 0, 15, 0);   // ready on the last allowed waiting cycle
        run_instr(6'd43, 0, 0, 15);

        // Memory never answers in FETCH: 16 waiting cycles, then ERROR until cleared.
        for (int i = 0; i < 16; i++) do_cycle(FETCH, 6'd0, 0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(ERROR, 6'd0, 0, 1'b0);
        clear_err_i = 1;
        do_cycle(ERROR, 6'd0, 0, 1'b0);
        clear_err_i = 0;
        run_instr(6'd35, 0, 0, 0);

        // Timeout inside MEM_RD.
        run_instr(6'd35, 0, 0, 0);
        do_cycle(FETCH, 6'd35, 0, 1'b1);
        do_cycle(DECODE, 6'd35, 0, 1'b0);
        do_cycle(MEM_ADDR, 6'd35, 0, 1'b0);
        for (int i = 0; i < 16; i++) do_cycle(MEM_RD, 6'd35, 0, 1'b0);
        do_cycle(ERROR, 6'd35, 0, 1'b1);
        clear_err_i = 1;
        do_cycle(ERROR, 6'd35, 0, 1'b1);
        clear_err_i = 0;

        // Asynchronous reset in the middle of MEM_RD.
        do_cycle(FETCH, 6'd35, 0, 1'b1);
        do_cycle(DECODE, 6'd35, 0, 1'b0);
        do_cycle(MEM_ADDR, 6'd35, 0, 1'b0);
        #2;
        check("pre_rst_state", 32'(state_o), 32'(MEM_RD));
        check("pre_rst_req", 32'(mem_req_o), 32'd1);
        rst_i = 0;
        #1;
        check("async_rst_state", 32'(state_o), 32'(FETCH));
        check("async_rst_outs", 32'(pack_outs()), 32'd0);
        @(negedge clk_i);
        check("held_rst_outs", 32'(pack_outs()), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1;

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 7)];
            if (op == 6'd63) op = 6'($urandom_range(0, 63));
            run_instr(op, rnd_bit(), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
